// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter sharing four result-forwarding buses
// among NUM_REQ functional-unit result producers.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   flush        synchronous squash of this cycle's arbitration
//   req_valid    per-requester result-valid
//   req_data     per-requester {rob[5:0], value[15:0]}, 22 bits per slice
//   req_ready    per-requester grant, combinational
//   forwardA..D  registered {valid, rob, value} result buses
//   grant_count  registered number of valid buses (0..4)
//   dup_tag_err  sticky flag: two buses carried the same rob tag
module cdb_arbiter #(
    parameter int NUM_REQ = 6,
    parameter int PTR_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*22-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [22:0]           forwardA,
    output logic [22:0]           forwardB,
    output logic [22:0]           forwardC,
    output logic [22:0]           forwardD,
    output logic [2:0]            grant_count,
    output logic                  dup_tag_err
);

    localparam int NBUS  = 4;
    localparam int DW    = 22;
    localparam int NSLOT = 2 ** PTR_W;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic [PTR_W-1:0] last_idx;

    // Requester state padded to the full pointer range so every
    // PTR_W-bit index is in bounds; unused slots read as idle.
    logic [NSLOT-1:0] valid_pad;
    logic [NSLOT-1:0] grant_pad;
    logic [DW-1:0]    slot [NSLOT];

    logic [PTR_W-1:0] sel [NBUS];
    logic [NBUS-1:0]  sel_vld;
    logic [2:0]       cnt;
    logic [22:0]      bus_nxt [NBUS];
    logic             dup_hit;

    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        if (i < NUM_REQ) begin : g_used
            assign valid_pad[i] = req_valid[i];
            assign slot[i]      = req_data[i*DW +: DW];
        end else begin : g_pad
            assign valid_pad[i] = 1'b0;
            assign slot[i]      = '0;
        end
    end

    // Scan from rr_ptr with wrap; the first four valid requesters
    // land on buses A..D in scan order.
    always_comb begin
        logic [PTR_W:0] idx;
        grant_pad = '0;
        sel_vld   = '0;
        cnt       = '0;
        last_idx  = rr_ptr;
        idx       = '0;
        for (int j = 0; j < NBUS; j++) begin
            sel[j] = '0;
        end
        if (!rst && !flush) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (idx >= (PTR_W+1)'(NUM_REQ)) begin
                    idx = idx - (PTR_W+1)'(NUM_REQ);
                end
                if (valid_pad[idx[PTR_W-1:0]] && cnt < 3'd4) begin
                    grant_pad[idx[PTR_W-1:0]] = 1'b1;
                    sel[cnt[1:0]]     = idx[PTR_W-1:0];
                    sel_vld[cnt[1:0]] = 1'b1;
                    cnt               = cnt + 3'd1;
                    last_idx          = idx[PTR_W-1:0];
                end
            end
        end
    end

    assign req_ready = grant_pad[NUM_REQ-1:0];

    // Idle buses carry all-zero payload, not stale data.
    always_comb begin
        for (int j = 0; j < NBUS; j++) begin
            bus_nxt[j] = '0;
            if (sel_vld[j]) begin
                bus_nxt[j] = {1'b1, slot[sel[j]]};
            end
        end
    end

    always_comb begin
        dup_hit = 1'b0;
        for (int j = 0; j < NBUS; j++) begin
            for (int l = j + 1; l < NBUS; l++) begin
                if (sel_vld[j] && sel_vld[l] &&
                    bus_nxt[j][21:16] == bus_nxt[l][21:16]) begin
                    dup_hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_nxt = last_idx + PTR_W'(1);
        if (last_idx == PTR_W'(NUM_REQ - 1)) begin
            ptr_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            forwardA    <= '0;
            forwardB    <= '0;
            forwardC    <= '0;
            forwardD    <= '0;
            grant_count <= '0;
            dup_tag_err <= 1'b0;
        end else if (flush) begin
            rr_ptr      <= '0;
            forwardA    <= '0;
            forwardB    <= '0;
            forwardC    <= '0;
            forwardD    <= '0;
            grant_count <= '0;
        end else begin
            forwardA    <= bus_nxt[0];
            forwardB    <= bus_nxt[1];
            forwardC    <= bus_nxt[2];
            forwardD    <= bus_nxt[3];
            grant_count <= cnt;
            if (cnt != 3'd0) begin
                rr_ptr <= ptr_nxt;
            end
            if (dup_hit) begin
                dup_tag_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the four result-forwarding buses (forwardA..forwardD) among NUM_REQ functional-unit result producers.
- Each cycle it grants up to four valid requesters in round-robin order. It registers their {rob tag, value} onto the buses, which feed every reservation station and the ROB.
- It also handles pipeline flush and guarantees bounded wait for every requester.

Parameters:
- NUM_REQ, 6, number of result producers; legal range 1..16.
- PTR_W, 4, width of the round-robin pointer; must satisfy 2^PTR_W >= NUM_REQ.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash: discard this cycle's arbitration.
- req_valid  input  NUM_REQ  bit i = requester i holds a result.
- req_data  input  NUM_REQ*22  slice i = bits [22*i+21:22*i] = {rob[5:0], value[15:0]}.
- req_ready  output  NUM_REQ  bit i = requester i granted this cycle; combinational.
- forwardA  output  23  {valid, rob[5:0], value[15:0]}; registered.
- forwardB  output  23  same format as forwardA.
- forwardC  output  23  same format as forwardA.
- forwardD  output  23  same format as forwardA.
- grant_count  output  3  number of valid buses currently driven (0..4); registered.
- dup_tag_err  output  1  sticky: two buses carried the same rob tag in one cycle.

Behaviour:
- State: rr_ptr[PTR_W-1:0], the four forward registers, grant_count, dup_tag_err.
- Reset (async, rst=1):
  - rr_ptr=0.
  - forwardA..D=23'b0.
  - grant_count=0.
  - dup_tag_err=0.
  - req_ready forced to all zeros while rst=1.
- Handshake: transfer on requester i occurs when req_valid[i] && req_ready[i] in the same cycle. The requester must hold valid and data stable until transferred. req_ready may only rise for a requester whose req_valid is high.
- Arbitration (combinational):
  - Scan indices rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - The first up to four requesters with req_valid=1 are granted.
  - Grants map in scan order to bus A, B, C, D.
  - Buses with no grant carry valid=0, and their rob/value fields must be zero.
- Latency: a granted result appears on its forward bus exactly one cycle after the grant cycle, held for exactly one cycle.
- Pointer update on an edge with >=1 grant and flush=0: rr_ptr <= (index of the last granted requester + 1) mod NUM_REQ.
- Pointer with no grants: rr_ptr unchanged.
- Fairness: any requester holding valid continuously is granted within ceil(NUM_REQ/4) cycles.
- grant_count: registered popcount of the grants, aligned with the forward buses.
- flush=1:
  - req_ready = all zeros that cycle.
  - Next edge: forwardA..D=0, grant_count=0, rr_ptr=0.
  - Requesters keep their results unless they squash them themselves.
- dup_tag_err: set on any edge where two newly loaded buses with valid=1 share a rob tag. Cleared only by rst.
- Boundary cases:
  - NUM_REQ<=4 with all requesters valid: all are granted every cycle.
  - Zero valid requesters: all buses are invalid next cycle.
  - Pointer wrap from NUM_REQ-1 to 0 must not skip or double-grant any index.
  - Reset asserted mid-operation: bus contents are lost immediately and asynchronously; the first grant after reset release starts scanning at index 0.

Test Plan:
- Reset, then rst low with req_valid=0 -> forwardA..D=0, grant_count=0, req_ready=0, rr_ptr=0.
- NUM_REQ=6, only req 2 valid with rob=5, value=16'h1234 -> req_ready=6'b000100. Next cycle forwardA=23'h451234 ({1,6'd5,16'h1234}); B..D=0; grant_count=1; rr_ptr=3.
- All 6 valid from rr_ptr=0 ->
  - cycle 0: grants 0..3 on A..D, rr_ptr=4;
  - cycle 1: grants 4,5,0,1, rr_ptr=2.
  - No requester waits more than 2 cycles.
- rr_ptr=5 with reqs 5 and 1 valid -> req 5 goes to A and req 1 to B; rr_ptr becomes 2 (wrap check).
- flush=1 while 3 requesters are valid -> req_ready=0. Next cycle all buses invalid, grant_count=0, rr_ptr=0. Requesters are granted normally the cycle after flush drops.
- Two valid requesters both carrying rob=6'd9 -> both granted; dup_tag_err=1 the following cycle and stays 1 until rst.
